// File: rtl/dca_matrix_block_merger_pkg.sv
// Shared encodings for the DCA matrix block merger: element sizes, FSM states
// and the tile walk order used by both the splitter and the merger.
package dca_matrix_block_merger_pkg;

    localparam logic [1:0] ELEM_8B  = 2'd0;
    localparam logic [1:0] ELEM_16B = 2'd1;
    localparam logic [1:0] ELEM_32B = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } merger_state_e;

    typedef enum logic {
        ORDER_ROW_MAJOR = 1'b0,
        ORDER_COL_FIRST = 1'b1
    } tile_order_e;

    // Encoding 3 has no wider element behind it, so it aliases to 32-bit.
    function automatic logic [1:0] norm_elem_log2(input logic [1:0] e);
        return (e == 2'd3) ? ELEM_32B : e;
    endfunction

endpackage

// File: rtl/dca_matrix_row_packer.sv
// Packs one tile row of 32-bit lanes down to the element width and builds the
// matching byte strobes; masked lanes contribute neither data nor strobe.
module dca_matrix_row_packer
    import dca_matrix_block_merger_pkg::*;
#(
    parameter int NUM_LANES = 4
) (
    input  logic [NUM_LANES*32-1:0] lanes_i,
    input  logic [1:0]              elem_log2_i,
    input  logic [NUM_LANES-1:0]    lane_mask_i,
    output logic [NUM_LANES*32-1:0] data_o,
    output logic [NUM_LANES*4-1:0]  strb_o
);

    always_comb begin
        data_o = '0;
        strb_o = '0;
        for (int c = 0; c < NUM_LANES; c++) begin
            if (lane_mask_i[c]) begin
                case (elem_log2_i)
                    ELEM_8B: begin
                        data_o[c*8 +: 8] = lanes_i[c*32 +: 8];
                        strb_o[c]        = 1'b1;
                    end
                    ELEM_16B: begin
                        data_o[c*16 +: 16] = lanes_i[c*32 +: 16];
                        strb_o[c*2 +: 2]   = 2'b11;
                    end
                    default: begin
                        data_o[c*32 +: 32] = lanes_i[c*32 +: 32];
                        strb_o[c*4 +: 4]   = 4'hF;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/dca_matrix_block_merger.sv
// Tile-row write merger: walks tiles in splitter order, drops overhang rows and
// lanes, and issues one byte-addressed write request per valid row.
module dca_matrix_block_merger
    import dca_matrix_block_merger_pkg::*;
#(
    parameter int MATRIX_NUM_ROW = 4,
    parameter int MATRIX_NUM_COL = 4,
    parameter int BW_ADDR        = 32,
    parameter int BW_DIM         = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [BW_ADDR-1:0]          cfg_base_addr,
    input  logic [BW_ADDR-1:0]          cfg_stride,
    input  logic [BW_DIM-1:0]           cfg_num_row_m1,
    input  logic [BW_DIM-1:0]           cfg_num_col_m1,
    input  logic [1:0]                  cfg_elem_log2,
    input  logic                        cfg_is_col_first,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [MATRIX_NUM_COL*32-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [BW_ADDR-1:0]          out_addr,
    output logic [MATRIX_NUM_COL*32-1:0] out_data,
    output logic [MATRIX_NUM_COL*4-1:0] out_strb,
    output logic                        busy,
    output logic                        done
);

    localparam int LOG2R = $clog2(MATRIX_NUM_ROW);
    localparam int LOG2C = $clog2(MATRIX_NUM_COL);
    localparam int RW    = (LOG2R > 0) ? LOG2R : 1;
    localparam int GW    = BW_DIM + LOG2R + 1;
    localparam int CW    = BW_DIM + LOG2C + 1;

    merger_state_e state_q, state_d;

    logic [BW_ADDR-1:0] base_q, stride_q;
    logic [BW_DIM-1:0]  nrm1_q, ncm1_q;
    logic [1:0]         elem_q;
    tile_order_e        order_q;

    logic [BW_DIM-1:0]  tx_q, tx_d, ty_q, ty_d;
    logic [RW-1:0]      r_q, r_d;
    logic [BW_ADDR-1:0] tile_row_addr_q, tile_row_addr_d;
    logic [BW_ADDR-1:0] row_addr_q, row_addr_d;
    logic [BW_ADDR-1:0] col_off_q, col_off_d;

    logic                         out_valid_q, out_valid_d;
    logic [BW_ADDR-1:0]           out_addr_q, out_addr_d;
    logic [MATRIX_NUM_COL*32-1:0] out_data_q, out_data_d;
    logic [MATRIX_NUM_COL*4-1:0]  out_strb_q, out_strb_d;

    logic                         tx_last, ty_last, r_last, row_valid, beat_fire;
    logic [GW-1:0]                gr;
    logic [CW-1:0]                col_base;
    logic [MATRIX_NUM_COL-1:0]    lane_mask;
    logic [BW_ADDR-1:0]           tile_row_step, col_step;
    logic [MATRIX_NUM_COL*32-1:0] pack_data;
    logic [MATRIX_NUM_COL*4-1:0]  pack_strb;

    assign tx_last   = (tx_q == (ncm1_q >> LOG2C));
    assign ty_last   = (ty_q == (nrm1_q >> LOG2R));
    assign r_last    = (r_q == RW'(MATRIX_NUM_ROW - 1));
    assign gr        = (GW'(ty_q) << LOG2R) | GW'(r_q);
    assign row_valid = (gr <= GW'(nrm1_q));
    assign col_base  = CW'(tx_q) << LOG2C;

    // Address steps are shifts only: tile rows advance by stride*ROWS, tile
    // columns by COLS elements of the current size.
    assign tile_row_step = stride_q << LOG2R;
    assign col_step      = BW_ADDR'(MATRIX_NUM_COL) << elem_q;

    always_comb begin
        lane_mask = '0;
        for (int c = 0; c < MATRIX_NUM_COL; c++) begin
            lane_mask[c] = ((col_base + CW'(c)) <= CW'(ncm1_q));
        end
    end

    dca_matrix_row_packer #(
        .NUM_LANES (MATRIX_NUM_COL)
    ) u_packer (
        .lanes_i     (in_data),
        .elem_log2_i (elem_q),
        .lane_mask_i (lane_mask),
        .data_o      (pack_data),
        .strb_o      (pack_strb)
    );

    assign in_ready  = (state_q == ST_RUN) && (!out_valid_q || out_ready);
    assign beat_fire = in_valid && in_ready;
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_FIN);
    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;
    assign out_strb  = out_strb_q;

    always_comb begin
        state_d         = state_q;
        tx_d            = tx_q;
        ty_d            = ty_q;
        r_d             = r_q;
        tile_row_addr_d = tile_row_addr_q;
        row_addr_d      = row_addr_q;
        col_off_d       = col_off_q;
        out_valid_d     = out_valid_q && !out_ready;
        out_addr_d      = out_addr_q;
        out_data_d      = out_data_q;
        out_strb_d      = out_strb_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d         = ST_RUN;
                    tx_d            = '0;
                    ty_d            = '0;
                    r_d             = '0;
                    tile_row_addr_d = cfg_base_addr;
                    row_addr_d      = cfg_base_addr;
                    col_off_d       = '0;
                end
            end
            ST_RUN: begin
                if (beat_fire) begin
                    if (row_valid) begin
                        out_valid_d = 1'b1;
                        out_addr_d  = row_addr_q + col_off_q;
                        out_data_d  = pack_data;
                        out_strb_d  = pack_strb;
                    end
                    if (r_last) begin
                        r_d = '0;
                        if (order_q == ORDER_COL_FIRST) begin
                            if (ty_last) begin
                                ty_d            = '0;
                                tx_d            = tx_q + 1'b1;
                                tile_row_addr_d = base_q;
                                row_addr_d      = base_q;
                                col_off_d       = col_off_q + col_step;
                            end else begin
                                ty_d            = ty_q + 1'b1;
                                tile_row_addr_d = tile_row_addr_q + tile_row_step;
                                row_addr_d      = tile_row_addr_q + tile_row_step;
                            end
                        end else begin
                            if (tx_last) begin
                                tx_d            = '0;
                                ty_d            = ty_q + 1'b1;
                                tile_row_addr_d = tile_row_addr_q + tile_row_step;
                                row_addr_d      = tile_row_addr_q + tile_row_step;
                                col_off_d       = '0;
                            end else begin
                                tx_d       = tx_q + 1'b1;
                                row_addr_d = tile_row_addr_q;
                                col_off_d  = col_off_q + col_step;
                            end
                        end
                        if (tx_last && ty_last) begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        r_d        = r_q + 1'b1;
                        row_addr_d = row_addr_q + stride_q;
                    end
                end
            end
            ST_DRAIN: begin
                if (!out_valid_q || out_ready) begin
                    state_d = ST_FIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            tx_q            <= '0;
            ty_q            <= '0;
            r_q             <= '0;
            tile_row_addr_q <= '0;
            row_addr_q      <= '0;
            col_off_q       <= '0;
            out_valid_q     <= 1'b0;
            out_addr_q      <= '0;
            out_data_q      <= '0;
            out_strb_q      <= '0;
        end else begin
            state_q         <= state_d;
            tx_q            <= tx_d;
            ty_q            <= ty_d;
            r_q             <= r_d;
            tile_row_addr_q <= tile_row_addr_d;
            row_addr_q      <= row_addr_d;
            col_off_q       <= col_off_d;
            out_valid_q     <= out_valid_d;
            out_addr_q      <= out_addr_d;
            out_data_q      <= out_data_d;
            out_strb_q      <= out_strb_d;
        end
    end

    // Configuration is only meaningful once a run starts, so it carries no reset.
    always_ff @(posedge clk) begin
        if (!rst && state_q == ST_IDLE && start) begin
            base_q   <= cfg_base_addr;
            stride_q <= cfg_stride;
            nrm1_q   <= cfg_num_row_m1;
            ncm1_q   <= cfg_num_col_m1;
            elem_q   <= norm_elem_log2(cfg_elem_log2);
            order_q  <= tile_order_e'(cfg_is_col_first);
        end
    end

endmodule

// File: doc/dca_matrix_block_merger.md
Name: dca_matrix_block_merger

Overview:
- Write-side counterpart of the DCA matrix block splitter.
- Accepts computed tiles of MATRIX_NUM_ROW x MATRIX_NUM_COL elements as a row-per-beat stream, in the same tile order the splitter produces.
- Packs each row to the destination element width and masks edge-tile overhang.
- Emits one byte-addressed memory write request per valid tile row toward the LSU.

Parameters:
- MATRIX_NUM_ROW, 4, rows per tile (power of two, at least 1).
- MATRIX_NUM_COL, 4, columns per tile, i.e. lanes per input beat (power of two, at least 1).
- BW_ADDR, 32, byte address width.
- BW_DIM, 16, width of the num_row_m1 and num_col_m1 fields.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- cfg_base_addr  in  BW_ADDR  destination byte address of element (0,0).
- cfg_stride  in  BW_ADDR  row stride in bytes.
- cfg_num_row_m1  in  BW_DIM  matrix rows minus 1.
- cfg_num_col_m1  in  BW_DIM  matrix columns minus 1.
- cfg_elem_log2  in  2  element size: 0 = 8b, 1 = 16b, 2 = 32b; 3 is treated as 2.
- cfg_is_col_first  in  1  tile order: 1 = walk down tile rows first.
- in_valid  in  1  tile-row beat valid.
- in_ready  out  1  merger accepts the beat.
- in_data  in  MATRIX_NUM_COL*32  one 32-bit lane per column; the element sits in the lane's low bits.
- out_valid  out  1  write request valid.
- out_ready  in  1  LSU accepts the request.
- out_addr  out  BW_ADDR  byte address of the row's first element.
- out_data  out  MATRIX_NUM_COL*32  packed elements; element i at [i*W +: W], W = 8<<elem_log2.
- out_strb  out  MATRIX_NUM_COL*4  byte enables in the same packing.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after the last request handshakes.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - FSM goes to IDLE.
  - busy, done, out_valid, in_ready = 0.
  - out_addr, out_data, out_strb = 0.
  - All counters = 0.
  - Reset mid-run abandons the matrix; no further requests are issued.
- FSM states: IDLE, RUN, DRAIN, FIN.
  - IDLE, start=1: latch all cfg_*; clear the tile counters (tx, ty) and the row counter r; go to RUN. busy rises the next cycle.
  - IDLE: start=0 is a no-op. start outside IDLE is ignored.
  - RUN: in_ready = !out_valid | out_ready (single-entry output register, full throughput).
  - RUN, beat accepted with r == MATRIX_NUM_ROW-1 of the final tile: go to DRAIN.
  - DRAIN: in_ready=0. Wait until out_valid=0, or until the out_valid&out_ready handshake completes; then go to FIN.
  - FIN: done=1 for one cycle; busy=0 from this cycle; go to IDLE.
- Tile geometry:
  - Tile counts: NTY = (num_row_m1 >> log2 MATRIX_NUM_ROW) + 1; NTX likewise for columns.
  - Row-major order: tx increments first and wraps to 0 with ty+1.
  - Column-first order: ty increments first.
- Valid rows and columns:
  - Global row gr = ty*MATRIX_NUM_ROW + r. The row is valid iff gr <= num_row_m1.
  - Column lane c is valid iff tx*MATRIX_NUM_COL + c <= num_col_m1.
- Every beat is consumed, including overhang rows. A beat for an invalid row produces no request and does not load the output register.
- Address arithmetic:
  - out_addr = base + gr*stride + (tx*MATRIX_NUM_COL << elem_log2), modulo 2^BW_ADDR.
  - Implement incrementally with a row accumulator and a tile-base accumulator (no multipliers). Saturate nothing; wrap is silent.
- Packing and masking:
  - Lane c is truncated to W bits and placed at [c*W +: W].
  - Unused upper output bits = 0.
  - strb covers (1<<elem_log2) bytes per valid lane; invalid lanes give strb=0 and data=0.
- Output stability: while out_valid=1 and out_ready=0, out_addr, out_data and out_strb hold.
- The r counter wraps to 0 after MATRIX_NUM_ROW beats and advances the tile counters.
- in_valid in IDLE, DRAIN or FIN is not accepted (in_ready=0).

Decomposition:
- Shared package/header:
  - elem-size encoding constants (8b/16b/32b),
  - FSM state encoding,
  - the tile-order encoding shared with the splitter.
- One natural sub-module: dca_matrix_row_packer, a combinational block taking lanes, elem_log2 and the valid-lane mask, and producing packed data and strobe.
- The tile/row counter logic stays in the top level.

Test Plan:
- Row-major, 4x4 tiles, 6x5 matrix (num_row_m1=5, num_col_m1=4), 32-bit, base 0x1000, stride 32 -> 16 beats accepted, exactly 12 requests.
  - Tile(0,1) row0: addr 0x1010, strb 0x000F.
  - Tile(1,0) first request: addr 0x1080, strb 0xFFFF.
  - Rows 6 and 7 of tile row 1 are dropped.
  - done pulses once after the last handshake.
- Same config with cfg_is_col_first=1 -> request order follows tiles (0,0), (1,0), (0,1), (1,1); 5th request addr 0x1080.
- 8-bit 1x4 matrix, lanes 0x11, 0x22, 0x33, 0x44 (upper lane bits 0xFFFFFF) -> out_data low word 0x44332211, strb 0x000F, one request.
- 16-bit 1x3 matrix -> out_data[47:0] holds lanes 0..2 at 16b each; strb 0x003F; bytes 6..15 have strb 0.
- Backpressure: hold out_ready=0 for 3 cycles with out_valid=1 -> outputs stable and in_ready=0; resume -> no loss or duplication.
- Assert rst mid-RUN after 5 beats -> next cycle: busy=0, out_valid=0, in_ready=0; a new start then produces the full correct sequence.
